// File: rtl/muldiv_unit_pkg.sv
// Shared types and operation decoding for the iterative RV32M multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OpMul    = 3'd0,
        OpMulh   = 3'd1,
        OpMulhsu = 3'd2,
        OpMulhu  = 3'd3,
        OpDiv    = 3'd4,
        OpDivu   = 3'd5,
        OpRem    = 3'd6,
        OpRemu   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
               (op == OpDiv) || (op == OpRem);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MUL_STEP-bit shift-add multiply, radix-2 restoring divide,
// single-cycle path for divide-by-zero and signed overflow.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_STEP = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            go_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;
    localparam logic [CntW-1:0] MulSteps = CntW'(XLEN / MUL_STEP);
    localparam logic [CntW-1:0] DivSteps = CntW'(XLEN);

    muldiv_state_t     state_q, state_d;
    muldiv_op_t        op_q, op_d, op_in;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_q, neg_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2*XLEN-1:0] mul_acc, div_acc, prod;
    logic [XLEN:0]     sum, rem_sh, diff;
    logic [XLEN-1:0]   quot, rem, fin_res;
    logic              sa, sb, div_zero, div_ovf;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign op_in    = muldiv_op_t'(op_i);
    assign sa       = op_a_signed(op_in) & a_i[XLEN-1];
    assign sb       = op_b_signed(op_in) & b_i[XLEN-1];
    assign div_zero = (b_i == '0);
    assign div_ovf  = ((op_in == OpDiv) || (op_in == OpRem)) &&
                      (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

    // Multiply: high half accumulates the multiplicand, low half shifts out multiplier bits.
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    always_comb begin
        sum     = '0;
        mul_acc = acc_q;
        for (int i = 0; i < int'(MUL_STEP); i++) begin
            sum     = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, opb_q} : '0);
            mul_acc = {sum, mul_acc[XLEN-1:1]};
        end
        rem_sh  = acc_q[2*XLEN-1:XLEN-1];
        diff    = rem_sh - {1'b0, opb_q};
        div_acc = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                             : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_q ? -mul_acc : mul_acc;
        quot = div_acc[XLEN-1:0];
        rem  = div_acc[2*XLEN-1:XLEN];
        unique case (op_q)
            OpMul:                   fin_res = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin_res = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:           fin_res = mag(quot, neg_q);
            OpRem, OpRemu:           fin_res = mag(rem, negr_q);
            default:                 fin_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (go_i) begin
                    op_d   = op_in;
                    neg_d  = sa ^ sb;
                    negr_d = sa;
                    if (op_is_div(op_in)) begin
                        acc_d = {{XLEN{1'b0}}, mag(a_i, sa)};
                        opb_d = mag(b_i, sb);
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mag(b_i, sb)};
                        opb_d = mag(a_i, sa);
                    end
                    if (op_is_div(op_in) && div_zero) begin
                        result_d = op_in[1] ? a_i : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = op_in[1] ? '0 : a_i;
                        state_d  = StDone;
                    end else begin
                        cnt_d   = op_is_div(op_in) ? DivSteps : MulSteps;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                acc_d = op_is_div(op_q) ? div_acc : mul_acc;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    result_d = fin_res;
                    state_d  = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (kill_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            op_q     <= OpMul;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q != StIdle);
    assign done_o   = (state_q == StDone);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit at MUL_STEP 4, 1 and 8 against a plain-arithmetic RV32M model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        go = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  busy, done;
    logic [31:0] res [3];

    int n_cmp = 0;
    int n_err = 0;
    int steps [3] = '{4, 1, 8};

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .go_i(go), .op_i(op), .a_i(a), .b_i(b), .kill_i(kill),
        .busy_o(busy[0]), .done_o(done[0]), .result_o(res[0])
    );
    muldiv_unit #(.XLEN(32), .MUL_STEP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .go_i(go), .op_i(op), .a_i(a), .b_i(b), .kill_i(kill),
        .busy_o(busy[1]), .done_o(done[1]), .result_o(res[1])
    );
    muldiv_unit #(.XLEN(32), .MUL_STEP(8)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .go_i(go), .op_i(op), .a_i(a), .b_i(b), .kill_i(kill),
        .busy_o(busy[2]), .done_o(done[2]), .result_o(res[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic is_ovf(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        return (o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (is_ovf(o, x, y)) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (is_ovf(o, x, y)) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Called #1 after a rising edge; that cycle is cycle 0 of the operation.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input string tag, output logic [31:0] r0);
        int first [3];
        int pulses [3];
        logic [31:0] got [3];
        logic [31:0] exp;
        int lat;
        exp = model(o, x, y);
        for (int i = 0; i < 3; i++) begin
            first[i] = -1;
            pulses[i] = 0;
            got[i] = '0;
        end
        op = o; a = x; b = y; go = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                go = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
            end
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    pulses[i]++;
                    if (first[i] < 0) begin
                        first[i] = k;
                        got[i] = res[i];
                    end
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (o[2]) lat = (y == 0 || is_ovf(o, x, y)) ? 1 : 33;
            else lat = 32 / steps[i] + 1;
            check($sformatf("%s res step%0d", tag, steps[i]), got[i], exp);
            check($sformatf("%s lat step%0d", tag, steps[i]), first[i], lat);
            check($sformatf("%s pulses step%0d", tag, steps[i]), pulses[i], 1);
        end
        r0 = got[0];
    endtask

    task automatic abort_test(input bit use_reset, input string tag);
        logic [31:0] prev;
        logic [31:0] r;
        int pulses = 0;
        prev = res[0];
        op = 3'd4; a = $urandom; b = $urandom_range(1, 1000); go = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) go = 1'b0;
            pulses += int'(done[0]);
            if (k == 4) begin
                if (use_reset) reset_n = 1'b0;
                else kill = 1'b1;
            end
        end
        kill = 1'b0;
        reset_n = 1'b1;
        check({tag, " busy"}, busy, 3'b000);
        check({tag, " done"}, done, 3'b000);
        check({tag, " pulses"}, pulses, 0);
        check({tag, " result"}, res[0], use_reset ? 32'd0 : prev);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, {tag, " restart"}, r);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] x, y;
        logic [2:0]  o;
        int pulses;
        int c1, c2;
        logic [31:0] r1, r2;

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 3'b000);
        check("reset done", done, 3'b000);
        check("reset result", res[0], 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3", r);
        check("mul 7*-3 const", r, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu", r);
        check("mulhu const", r, 32'hFFFF_FFFE);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "mulh", r);
        check("mulh const", r, 32'h4000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu", r);
        check("mulhsu const", r, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div -7/2", r);
        check("div -7/2 const", r, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem -7,2", r);
        check("rem -7,2 const", r, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, "divu 100/7", r);
        check("divu const", r, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, "remu 100,7", r);
        check("remu const", r, 32'd2);
        run_op(3'd5, 32'd5, 32'd0, "divu 5/0", r);
        check("divu /0 const", r, 32'hFFFF_FFFF);
        run_op(3'd6, 32'd5, 32'd0, "rem 5,0", r);
        check("rem /0 const", r, 32'd5);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf", r);
        check("div ovf const", r, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf", r);
        check("rem ovf const", r, 32'd0);

        abort_test(1'b0, "kill");
        abort_test(1'b1, "reset");

        // go held high across two MULs on the MUL_STEP=4 instance
        pulses = 0; c1 = -1; c2 = -1; r1 = '0; r2 = '0;
        op = 3'd0; a = 32'd1234; b = 32'hFFFF_0001; go = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            if (done[0]) begin
                pulses++;
                if (pulses == 1) begin
                    c1 = k; r1 = res[0]; a = 32'hDEAD_BEEF; b = 32'h0000_1235;
                end else begin
                    c2 = k; r2 = res[0]; go = 1'b0;
                end
            end
        end
        go = 1'b0;
        check("b2b pulses", pulses, 2);
        check("b2b first cycle", c1, 9);
        check("b2b second cycle", c2, 19);
        check("b2b first res", r1, model(3'd0, 32'd1234, 32'hFFFF_0001));
        check("b2b second res", r2, model(3'd0, 32'hDEAD_BEEF, 32'h0000_1235));
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;

        for (int n = 0; n < 40; n++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = 32'd0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: y = $urandom_range(1, 15);
                default: ;
            endcase
            run_op(o, x, y, $sformatf("rand%0d op%0d", n, o), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit covering the full RV32M set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It replaces the fixed multiply-only core in the execute stage.
- Execute holds `go` while the instruction waits, stalls until `done`, then takes `result` as its ALU output.
- Multiply retires `MUL_STEP` bits per cycle; divide is radix-2 restoring, with a single-cycle fast path for special cases.

## Interface
- `XLEN`, default 32: operand and result width.
- `MUL_STEP`, default 4: multiplier bits consumed per cycle. Must be a power of 2 that divides `XLEN`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  level request. Sampled only in IDLE.
- `op`  in  3  `muldiv_op_t`: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `a`  in  `XLEN`  rs1 operand (multiplicand / dividend).
- `b`  in  `XLEN`  rs2 operand (multiplier / divisor).
- `kill`  in  1  flush. Aborts any operation and has priority over `go`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  `XLEN`  registered result. Holds its value until the next `done`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `go & ~kill` latches `a`, `b` and `op`.
  - Divide with `b==0`, or signed overflow (DIV/REM with `a==2^(XLEN-1)` and `b==all-ones`), goes straight to DONE.
  - Any other operation goes to RUN and loads the step counter.
- RUN:
  - Multiply uses `XLEN/MUL_STEP` steps; divide uses `XLEN` steps.
  - The last step goes to DONE.
- DONE: `done=1` for exactly one cycle, then IDLE unconditionally. `go` is ignored in DONE, so the still-asserted request of the finishing instruction cannot restart the unit.
- `kill` in any state: next state IDLE, counter cleared, `result` unchanged, no `done` pulse.
- Multiply:
  - Operands are converted to magnitudes. MUL/MULH treat `a` and `b` as signed; MULHSU treats `a` signed and `b` unsigned; MULHU treats both unsigned.
  - The unsigned shift-add accumulates a `2*XLEN` product.
  - The product is negated when the operand signs differ.
  - MUL returns `[XLEN-1:0]`; the MULH variants return `[2*XLEN-1:XLEN]`.
- Divide:
  - Operands are converted to magnitudes (signed for DIV/REM).
  - Restoring shift-subtract produces one quotient bit per cycle.
  - The quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Special cases, required values:
  - Divide by zero: quotient = all-ones, remainder = `a`.
  - Signed overflow: quotient = `2^(XLEN-1)`, remainder = 0.
- All arithmetic is modulo 2^`XLEN` (2^`2*XLEN` for the product). No internal exceptions are raised.

## Timing
- Cycle 0 is the first cycle `go` is high in IDLE.
- `done` is asserted in:
  - cycle `XLEN/MUL_STEP + 1` for multiply (cycle 9 at the defaults);
  - cycle `XLEN + 1` for regular divide (cycle 33);
  - cycle 1 for the divide fast path.
- A back-to-back request may be accepted in the cycle after `done` (IDLE), giving a one-cycle minimum gap between operations.
- Reset values: state IDLE, `busy=0`, `done=0`, `result=0`; counter and operand registers 0.
- Reset mid-operation behaves like `kill`: no `done`.
- Simultaneous `kill` and `go` in IDLE: not accepted.
- `kill` in DONE: `done` is still high that cycle, because it is registered; the state returns to IDLE.
- Operand inputs may change after cycle 0 without affecting the result.

## Structure
- `muldiv_op_t` goes in `defines.svh`, alongside `aluop_t` and `ecause_t`.
- Multiply and divide share a single datapath: one `2*XLEN` working register, one `XLEN+1` adder/subtractor, and a step counter of `$clog2(XLEN)+1` bits.
- No sub-module; sign pre- and post-processing are local functions.

## Test plan
- MUL `a=7`, `b=-3` -> `done` at cycle 9, `result=0xFFFFFFEB`. MULHU `0xFFFFFFFF*0xFFFFFFFF` -> `0xFFFFFFFE`.
- MULH `0x80000000*0x80000000` -> `0x40000000`. MULHSU `a=-1`, `b=0xFFFFFFFF` -> `0xFFFFFFFF`.
- DIV `-7/2` -> `0xFFFFFFFD` at cycle 33; REM `-7,2` -> `0xFFFFFFFF`; DIVU `100/7` -> 14; REMU `100,7` -> 2.
- DIVU `5/0` -> `0xFFFFFFFF` at cycle 1; REM `5,0` -> 5; DIV `0x80000000/-1` -> `0x80000000`; REM of the same operands -> 0.
- Assert `kill` at cycle 4 of a DIV -> no `done`, `busy=0` at cycle 5. A `go` at cycle 5 is accepted and completes normally. Hold `reset_n` low in RUN -> same behaviour.
- Hold `go` high across two consecutive MULs -> exactly one `done` per operation. The second operation starts the cycle after the first `done`. Run a `MUL_STEP=1`/`MUL_STEP=8` sweep against a reference model using random operands.
